// File: rtl/demux_2_6_reg.sv
// 1-to-2 registered demultiplexer: steers each accepted source word into one of two
// single-word channel registers with valid/ready handshakes. Define CC_DEMUX_COUNT_EN for per-channel accept counters.
module demux_2_6_reg #(
  parameter int DATAWIDTH_DEMUX_SELECTION = 1,
  parameter int DATAWIDTH_BUS             = 6,
  parameter int DATAWIDTH_COUNT           = 8
) (
  input  logic                                 CC_DEMUX_CLOCK_50,
  input  logic                                 CC_DEMUX_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]             CC_DEMUX_data_InBUS,
  input  logic [DATAWIDTH_DEMUX_SELECTION-1:0] CC_DEMUX_selection_InBUS,
  input  logic                                 CC_DEMUX_valid_In,
  output logic                                 CC_DEMUX_ready_Out,
  output logic [DATAWIDTH_BUS-1:0]             CC_DEMUX_data0_OutBUS,
  output logic                                 CC_DEMUX_valid0_Out,
  input  logic                                 CC_DEMUX_ready0_In,
  output logic [DATAWIDTH_BUS-1:0]             CC_DEMUX_data1_OutBUS,
  output logic                                 CC_DEMUX_valid1_Out,
  input  logic                                 CC_DEMUX_ready1_In
`ifdef CC_DEMUX_COUNT_EN
  ,
  output logic [DATAWIDTH_COUNT-1:0]           CC_DEMUX_count0_OutBUS,
  output logic [DATAWIDTH_COUNT-1:0]           CC_DEMUX_count1_OutBUS
`endif
);

  logic [1:0]                    ready_in;
  logic [1:0]                    ready_ch;
  logic [1:0]                    load;
  logic [1:0]                    valid_q;
  logic [1:0]                    valid_d;
  logic [1:0][DATAWIDTH_BUS-1:0] data_q;
  logic [1:0][DATAWIDTH_BUS-1:0] data_d;
  logic                          sel_lsb;
  logic                          accept;

  assign ready_in = {CC_DEMUX_ready1_In, CC_DEMUX_ready0_In};
  assign sel_lsb  = CC_DEMUX_selection_InBUS[0];

  // A full channel can still take a word if its consumer drains it in the same cycle.
  assign ready_ch           = ~valid_q | ready_in;
  assign CC_DEMUX_ready_Out = ready_ch[sel_lsb];
  assign accept             = CC_DEMUX_valid_In & CC_DEMUX_ready_Out;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      always_comb begin
        load[gi]    = accept & (sel_lsb == gi[0]);
        valid_d[gi] = load[gi] | (valid_q[gi] & ~ready_in[gi]);
        data_d[gi]  = load[gi] ? CC_DEMUX_data_InBUS : data_q[gi];
      end

      always_ff @(posedge CC_DEMUX_CLOCK_50 or posedge CC_DEMUX_RESET_InHigh) begin
        if (CC_DEMUX_RESET_InHigh) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end
    end
  endgenerate

  assign CC_DEMUX_data0_OutBUS = data_q[0];
  assign CC_DEMUX_data1_OutBUS = data_q[1];
  assign CC_DEMUX_valid0_Out   = valid_q[0];
  assign CC_DEMUX_valid1_Out   = valid_q[1];

`ifdef CC_DEMUX_COUNT_EN
  logic [1:0][DATAWIDTH_COUNT-1:0] count_q;
  logic [1:0][DATAWIDTH_COUNT-1:0] count_d;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      // Free-running modulo counter; wrap from all-ones to zero is intended.
      always_comb begin
        count_d[gi] = load[gi] ? count_q[gi] + DATAWIDTH_COUNT'(1) : count_q[gi];
      end

      always_ff @(posedge CC_DEMUX_CLOCK_50 or posedge CC_DEMUX_RESET_InHigh) begin
        if (CC_DEMUX_RESET_InHigh) begin
          count_q[gi] <= '0;
        end else begin
          count_q[gi] <= count_d[gi];
        end
      end
    end
  endgenerate

  assign CC_DEMUX_count0_OutBUS = count_q[0];
  assign CC_DEMUX_count1_OutBUS = count_q[1];
`endif

endmodule

// File: tb/tb_demux_2_6_reg.sv
// Directed testbench for demux_2_6_reg; exercises the counter outputs when CC_DEMUX_COUNT_EN is defined.
module tb_demux_2_6_reg;

  logic       clk;
  logic       rst;
  logic [5:0] data_in;
  logic [0:0] sel;
  logic       valid_in;
  logic       ready_out;
  logic [5:0] data0;
  logic       valid0;
  logic       ready0;
  logic [5:0] data1;
  logic       valid1;
  logic       ready1;
`ifdef CC_DEMUX_COUNT_EN
  logic [7:0] count0;
  logic [7:0] count1;
`endif

  int checks = 0;
  int errors = 0;

  demux_2_6_reg dut (
    .CC_DEMUX_CLOCK_50        (clk),
    .CC_DEMUX_RESET_InHigh    (rst),
    .CC_DEMUX_data_InBUS      (data_in),
    .CC_DEMUX_selection_InBUS (sel),
    .CC_DEMUX_valid_In        (valid_in),
    .CC_DEMUX_ready_Out       (ready_out),
    .CC_DEMUX_data0_OutBUS    (data0),
    .CC_DEMUX_valid0_Out      (valid0),
    .CC_DEMUX_ready0_In       (ready0),
    .CC_DEMUX_data1_OutBUS    (data1),
    .CC_DEMUX_valid1_Out      (valid1),
    .CC_DEMUX_ready1_In       (ready1)
`ifdef CC_DEMUX_COUNT_EN
    ,
    .CC_DEMUX_count0_OutBUS   (count0),
    .CC_DEMUX_count1_OutBUS   (count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load one word into a channel (consumers stalled); returns at the following negedge.
  task automatic load_word(input logic s, input logic [5:0] w);
    data_in  = w;
    sel      = s;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    ready0 = 1'b0;
    ready1 = 1'b0;
    load_word(1'b0, 6'h15);
    load_word(1'b1, 6'h16);
    checks++;
    if (valid0 !== 1'b1 || valid1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill valid0=%b valid1=%b want 1 1", valid0, valid1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0 || data0 !== 6'h00 || data1 !== 6'h00) begin
      errors++;
      $display("FAIL reset_async v0=%b v1=%b d0=%h d1=%h want 0 0 00 00", valid0, valid1, data0, data1);
    end
    @(negedge clk);
    rst      = 1'b0;
    sel      = 1'b0;
    valid_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready ready_out=%b want 1", ready_out);
    end
    valid_in = 1'b0;
    @(negedge clk);
    $display("reset: channels cleared, ready_out=%b", ready_out);
  endtask

  task automatic test_single();
    ready0   = 1'b0;
    data_in  = 6'h2A;
    sel      = 1'b0;
    valid_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL single_ready ready_out=%b want 1", ready_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (valid0 !== 1'b1 || data0 !== 6'h2A || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_load v0=%b d0=%h v1=%b want 1 2a 0", valid0, data0, valid1);
    end
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    checks++;
    if (valid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_drain valid0=%b want 0", valid0);
    end
    $display("single: 2a routed to ch0 and drained");
  endtask

  task automatic test_back_to_back();
    logic [5:0] w;
    ready1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      w        = 6'(i);
      data_in  = w;
      sel      = 1'b1;
      valid_in = 1'b1;
      #1;
      checks++;
      if (ready_out !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready word=%h ready_out=%b want 1", w, ready_out);
      end
      @(negedge clk);
      checks++;
      if (valid1 !== 1'b1 || data1 !== w) begin
        errors++;
        $display("FAIL b2b_data v1=%b d1=%h want 1 %h", valid1, data1, w);
      end
      $display("b2b: word %h on ch1 -> d1=%h v1=%b", w, data1, valid1);
    end
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (valid1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain valid1=%b want 0", valid1);
    end
    ready1 = 1'b0;
  endtask

  task automatic test_backpressure();
    load_word(1'b0, 6'h11);
    data_in  = 6'h22;
    sel      = 1'b0;
    valid_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall ready_out=%b want 0", ready_out);
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b1 || data0 !== 6'h11 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold v0=%b d0=%h rdy=%b want 1 11 0", valid0, data0, ready_out);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_switch ready_out=%b want 1", ready_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    checks++;
    if (valid1 !== 1'b1 || data1 !== 6'h22 || data0 !== 6'h11) begin
      errors++;
      $display("FAIL bp_land v1=%b d1=%h d0=%h want 1 22 11", valid1, data1, data0);
    end
    $display("backpressure: 22 held then routed to ch1, ch0 kept 11");
    ready0 = 1'b1;
    ready1 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    ready1 = 1'b0;
  endtask

  task automatic test_simultaneous();
    load_word(1'b0, 6'h05);
    load_word(1'b1, 6'h06);
    ready0   = 1'b1;
    ready1   = 1'b1;
    data_in  = 6'h07;
    sel      = 1'b0;
    valid_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready ready_out=%b want 1", ready_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    ready0   = 1'b0;
    ready1   = 1'b0;
    checks++;
    if (valid0 !== 1'b1 || data0 !== 6'h07 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL simul_result v0=%b d0=%h v1=%b want 1 07 0", valid0, data0, valid1);
    end
    $display("simultaneous: ch0=%h v0=%b v1=%b", data0, valid0, valid1);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    checks++;
    if (valid0 !== 1'b0 || data0 !== 6'h07 || data1 !== 6'h06) begin
      errors++;
      $display("FAIL hold_after_drain v0=%b d0=%h d1=%h want 0 07 06", valid0, data0, data1);
    end
  endtask

`ifdef CC_DEMUX_COUNT_EN
  task automatic test_count();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready0 = 1'b1;
    ready1 = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 257; i++) begin
      data_in = 6'(i);
      sel     = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      data_in = 6'(i);
      sel     = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    checks++;
    if (count0 !== 8'h01 || count1 !== 8'h03) begin
      errors++;
      $display("FAIL count_value c0=%h c1=%h want 01 03", count0, count1);
    end
    $display("count: c0=%h c1=%h", count0, count1);
    rst = 1'b1;
    #1;
    checks++;
    if (count0 !== 8'h00 || count1 !== 8'h00) begin
      errors++;
      $display("FAIL count_reset c0=%h c1=%h want 00 00", count0, count1);
    end
    @(negedge clk);
    rst    = 1'b0;
    ready0 = 1'b0;
    ready1 = 1'b0;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    data_in  = '0;
    sel      = '0;
    valid_in = 1'b0;
    ready0   = 1'b0;
    ready1   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
`ifdef CC_DEMUX_COUNT_EN
    test_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_2_6_reg.md
Name: demux_2_6_reg

Overview:
- 1-to-2 registered demultiplexer: the distribution-side counterpart of the team's 2:1 selection mux.
- Takes one 6-bit source bus plus a channel select and steers each accepted word into one of two output channel registers.
- Each output channel holds one word with a valid/ready handshake.
- Sits between a single producer and two consumers, e.g. routing a result bus back to one of two register banks.

Parameters:
- DATAWIDTH_DEMUX_SELECTION, 1, width of the channel select; only its LSB is decoded.
- DATAWIDTH_BUS, 6, width of the data path.
- DATAWIDTH_COUNT, 8, width of the per-channel transfer counters (used only when the optional feature is enabled).

Ports:
- CC_DEMUX_CLOCK_50  input  1  single system clock, rising edge.
- CC_DEMUX_RESET_InHigh  input  1  asynchronous, active-high reset.
- CC_DEMUX_data_InBUS  input  DATAWIDTH_BUS  source word.
- CC_DEMUX_selection_InBUS  input  DATAWIDTH_DEMUX_SELECTION  destination channel; 0 selects ch0, 1 selects ch1.
- CC_DEMUX_valid_In  input  1  source word and selection are valid.
- CC_DEMUX_ready_Out  output  1  demux can accept the presented word this cycle.
- CC_DEMUX_data0_OutBUS  output  DATAWIDTH_BUS  ch0 held word.
- CC_DEMUX_valid0_Out  output  1  ch0 register full.
- CC_DEMUX_ready0_In  input  1  ch0 consumer takes the word.
- CC_DEMUX_data1_OutBUS  output  DATAWIDTH_BUS  ch1 held word.
- CC_DEMUX_valid1_Out  output  1  ch1 register full.
- CC_DEMUX_ready1_In  input  1  ch1 consumer takes the word.

Behaviour:
- Reset (async assert, released synchronously by design use):
  - data0/data1 clear to 0 and valid0/valid1 clear to 0.
  - ready_Out reflects the empty state, i.e. ready_Out = 1 whenever valid_In is presented.
  - A reset mid-transfer discards held words without completing any handshake.
- Channel state, per channel k: EMPTY (valid_k=0) and FULL (valid_k=1).
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on simultaneous drain and load: the new word replaces the old one, with no bubble.
- Drain_k = valid_k & ready_k_In.
- ready_Out is combinational:
  - sel=0: ready_Out = ~valid0 | ready0_In.
  - sel=1: ready_Out = ~valid1 | ready1_In.
  - ready_Out does not depend on valid_In.
- Accept = valid_In & ready_Out. On accept, the selected channel register loads data_InBUS at the next rising edge.
- Latency: the word is visible on data_k_OutBUS with valid_k=1 one cycle after accept.
- The unselected channel is untouched by an accept. It drains independently, so both channels may drain in the same cycle.
- Both channels FULL with neither consumer ready: ready_Out=0 for either selection and the source must hold its word.
  - The source must keep data and selection stable while valid_In=1 and ready_Out=0.
  - Changing the selection while stalled is allowed; ready_Out then tracks the new channel.
- data_k_OutBUS holds its last value when valid_k=0. Consumers must ignore it.
- The selection is decoded on LSB only: any value with LSB=1 routes to ch1.

Optional Feature:
- Macro: CC_DEMUX_COUNT_EN.
- Enabled:
  - Adds outputs CC_DEMUX_count0_OutBUS and CC_DEMUX_count1_OutBUS, each DATAWIDTH_COUNT wide.
  - Each counts accepts routed to its channel, wraps from all-ones to 0, and clears on reset.
  - The count updates on the same edge as the channel load.
- Disabled: the ports and counters are absent. Datapath behaviour is identical.

Test Plan:
- Reset check: assert reset with both channels holding words -> valid0=valid1=0 and data outputs 0 immediately, asynchronously; ready_Out=1 after release.
- Single routing:
  - Stimulus: data=6'h2A, sel=0, valid=1 for one cycle; ready0=0.
  - Response: next cycle valid0=1, data0=6'h2A, valid1=0.
  - Then ready0=1 -> valid0=0 the following cycle.
- Back-to-back, same channel:
  - Stimulus: words 6'h01, 6'h02, 6'h03 to ch1 with ready1 held 1.
  - Response: ready_Out=1 throughout; data1 shows 01, 02, 03 on consecutive cycles, with no bubble.
- Backpressure:
  - Stimulus: ch0 FULL (6'h11), ready0=0, present 6'h22 sel=0 -> ready_Out=0 and data0 stays 6'h11.
  - Switch sel=1 -> ready_Out=1 and 6'h22 lands in ch1.
- Simultaneous events:
  - Stimulus: ch0 FULL (6'h05); in one cycle ready0=1, ready1=1 with ch1 FULL (6'h06), and a new word 6'h07 sel=0.
  - Response: both drains complete; next cycle valid0=1, data0=6'h07, valid1=0.
- With CC_DEMUX_COUNT_EN:
  - Stimulus: 257 accepts to ch0 and 3 to ch1.
  - Response: count0=8'h01 (wrapped), count1=8'h03; after reset both counts are 0.
